klingon_seg_decoder: RTL and testbench

//  Receive side of the Klingon 7-segment glyph interface: samples segment lines A..G,

---
 rtl/klingon_seg_decoder.sv | 143 ++++++++++++++
 tb/tb_klingon_seg_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/klingon_seg_decoder.sv
// Receive side of the Klingon 7-segment glyph link: debounces the segment lines,
// decodes a stable glyph to a BCD digit and offers it once over valid/ready.
module klingon_seg_decoder #(
   parameter int         STABLE_CYCLES = 4,
   parameter logic [6:0] PAT0 = 7'h7E,
   parameter logic [6:0] PAT1 = 7'h30,
   parameter logic [6:0] PAT2 = 7'h6D,
   parameter logic [6:0] PAT3 = 7'h79,
   parameter logic [6:0] PAT4 = 7'h33,
   parameter logic [6:0] PAT5 = 7'h5B,
   parameter logic [6:0] PAT6 = 7'h5F,
   parameter logic [6:0] PAT7 = 7'h70,
   parameter logic [6:0] PAT8 = 7'h4F,
   parameter logic [6:0] PAT9 = 7'h7B
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   input  logic       E,
   input  logic       F,
   input  logic       G,
   output logic       O0,
   output logic       O1,
   output logic       O2,
   output logic       O3,
   output logic       digit_valid,
   input  logic       digit_ready,
   output logic       pattern_err,
   output logic [7:0] err_count
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [9:0][6:0] PATS = {PAT9, PAT8, PAT7, PAT6, PAT5,
                                       PAT4, PAT3, PAT2, PAT1, PAT0};

   typedef enum logic [1:0] {SETTLE, VALID, DONE} state_t;

   state_t          state, state_nxt;
   logic [6:0]      seg, seg_q, acc_pat, acc_pat_d;
   logic [CW-1:0]   cnt;
   logic            stable;
   logic            match_hit;
   logic [3:0]      match_idx;
   logic [3:0]      digit_q, digit_d;
   logic            valid_d, err_d;
   logic [7:0]      err_count_d;

   assign seg    = {A, B, C, D, E, F, G};
   assign stable = (cnt == CNT_MAX);
   assign {O0, O1, O2, O3} = digit_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q <= '0;
         cnt   <= '0;
      end else begin
         seg_q <= seg;
         if (seg != seg_q)
            cnt <= CW'(1);
         else if (cnt != CNT_MAX)
            cnt <= cnt + CW'(1);
      end
   end

   // Scan downwards so the lowest matching index wins on duplicate patterns.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no latch is inferred.
      match_hit = 1'b0;
      match_idx = '0;
      for (int k = 9; k >= 0; k--) begin
         if (seg_q == PATS[k]) begin
            match_hit = 1'b1;
            match_idx = 4'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= SETTLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SETTLE: if (stable) state_nxt = (seg_q != '0 && match_hit) ? VALID : DONE;
         VALID:  if (digit_ready) state_nxt = DONE;
         DONE:   if (seg_q != acc_pat) state_nxt = SETTLE;
         default: state_nxt = SETTLE;
      endcase
   end

   always_comb begin
      acc_pat_d   = acc_pat;
      digit_d     = digit_q;
      valid_d     = digit_valid;
      err_d       = 1'b0;
      err_count_d = err_count;
      case (state)
         SETTLE: begin
            if (stable) begin
               acc_pat_d = seg_q;
               if (seg_q == '0) begin
                  valid_d = 1'b0;
               end else if (match_hit) begin
                  digit_d = match_idx;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
                  if (err_count != 8'hFF)
                     err_count_d = err_count + 8'd1;
               end
            end
         end
         VALID: if (digit_ready) valid_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_pat     <= '0;
         digit_q     <= '0;
         digit_valid <= 1'b0;
         pattern_err <= 1'b0;
         err_count   <= '0;
      end else begin
         acc_pat     <= acc_pat_d;
         digit_q     <= digit_d;
         digit_valid <= valid_d;
         pattern_err <= err_d;
         err_count   <= err_count_d;
      end
   end

endmodule

// File: tb/tb_klingon_seg_decoder.sv
// Bench for klingon_seg_decoder: directed scenarios plus random glyph streams,
// all checked cycle by cycle against a behavioural model of the receiver.
module tb_klingon_seg_decoder;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       A, B, C, D, E, F, G;
   logic       O0, O1, O2, O3;
   logic       digit_valid, digit_ready, pattern_err;
   logic [7:0] err_count;

   klingon_seg_decoder #(.STABLE_CYCLES(SC)) dut (
      .clk(clk), .reset(reset),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
      .O0(O0), .O1(O1), .O2(O2), .O3(O3),
      .digit_valid(digit_valid), .digit_ready(digit_ready),
      .pattern_err(pattern_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   logic [6:0] pats [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h4F, 7'h7B};

   int total = 0;
   int bad   = 0;

   // Model of the receiver: run length of identical samples, plus whether a
   // digit is on offer and whether the current glyph has already been consumed.
   logic [6:0] m_segq, m_last;
   int         m_run;
   bit         m_valid, m_consumed, m_err;
   logic [3:0] m_o;
   int         m_cnt;

   int dut_hs, dut_errp, dut_vcyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int lookup(input logic [6:0] g);
      for (int i = 0; i < 10; i++)
         if (pats[i] == g) return i;
      return -1;
   endfunction

   task automatic set_seg(input logic [6:0] g);
      {A, B, C, D, E, F, G} = g;
   endtask

   task automatic tick();
      logic [6:0] g;
      logic       rdy, rst;
      int         k;
      g   = {A, B, C, D, E, F, G};
      rdy = digit_ready;
      rst = reset;
      if (digit_valid && digit_ready) dut_hs++;
      @(posedge clk);
      if (rst) begin
         m_segq = '0; m_last = '0; m_run = 0; m_valid = 0;
         m_consumed = 0; m_err = 0; m_o = '0; m_cnt = 0;
      end else begin
         m_err = 0;
         if (m_valid) begin
            if (rdy) begin m_valid = 0; m_consumed = 1; end
         end else if (m_consumed) begin
            if (m_segq != m_last) m_consumed = 0;
         end else if (m_run == SC) begin
            m_last = m_segq;
            k = lookup(m_segq);
            if (m_segq == '0) m_consumed = 1;
            else if (k >= 0) begin m_o = 4'(k); m_valid = 1; end
            else begin
               m_err = 1;
               m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
               m_consumed = 1;
            end
         end
         if (g != m_segq) m_run = 1;
         else if (m_run < SC) m_run++;
         m_segq = g;
      end
      @(negedge clk);
      check("valid", digit_valid, m_valid);
      check("digit", {O0, O1, O2, O3}, m_o);
      check("perr",  pattern_err, m_err);
      check("ecnt",  err_count, m_cnt);
      if (pattern_err) dut_errp++;
      if (digit_valid) dut_vcyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Edges until digit_valid rises, or -1 when the bound expires.
   task automatic run_until_valid(input int max, output int edges);
      edges = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (digit_valid) begin edges = i; break; end
      end
   endtask

   int e, hs0, ep0, vc0;

   initial begin
      reset = 1'b1; digit_ready = 1'b0; set_seg('0);
      dut_hs = 0; dut_errp = 0; dut_vcyc = 0;
      ticks(2);
      check("rst_valid", digit_valid, 0);
      check("rst_digit", {O0, O1, O2, O3}, 0);
      check("rst_ecnt",  err_count, 0);
      reset = 1'b0;

      // 1: constant 3 -> valid after edge 5, single cycle with ready high
      set_seg(7'h79); digit_ready = 1'b1;
      run_until_valid(10, e);
      check("s1_latency", e, 5);
      check("s1_digit", {O0, O1, O2, O3}, 4'b0011);
      tick();
      check("s1_one_cycle", digit_valid, 0);

      // 2: short 4 glyph is ignored, then 5 decodes 5 edges after the change
      set_seg(7'h33); ticks(3);
      set_seg(7'h5B);
      hs0 = dut_hs;
      run_until_valid(10, e);
      check("s2_latency", e, 5);
      check("s2_digit", {O0, O1, O2, O3}, 4'b0101);
      tick();
      check("s2_no_four", dut_hs - hs0, 1);

      // 3: 3 held under back-pressure while input moves to 7
      digit_ready = 1'b0; set_seg(7'h79);
      run_until_valid(10, e);
      check("s3_first", e, 5);
      ticks(3); set_seg(7'h70); ticks(7);
      check("s3_hold_digit", {O0, O1, O2, O3}, 4'b0011);
      check("s3_hold_valid", digit_valid, 1);
      digit_ready = 1'b1; tick();
      run_until_valid(3, e);
      check("s3_next_latency", e, 2);
      check("s3_next_digit", {O0, O1, O2, O3}, 4'b0111);
      tick();

      // 4: unknown glyph gives one error pulse per appearance
      ep0 = dut_errp; vc0 = dut_vcyc;
      set_seg(7'h7F); ticks(20);
      check("s4_pulses", dut_errp - ep0, 1);
      check("s4_count", err_count, 1);
      check("s4_no_digit", dut_vcyc - vc0, 0);
      set_seg('0); ticks(6);
      set_seg(7'h7F); ticks(20);
      check("s4_count2", err_count, 2);

      // 5: repeated digit needs a gap; a long hold emits once
      hs0 = dut_hs;
      set_seg(7'h30); ticks(10);
      set_seg('0);    ticks(5);
      set_seg(7'h30); ticks(10);
      check("s5_twice", dut_hs - hs0, 2);
      set_seg('0); ticks(5);
      hs0 = dut_hs;
      set_seg(7'h30); ticks(50);
      check("s5_once", dut_hs - hs0, 1);

      // 6: reset drops a pending digit
      set_seg('0); ticks(6);
      digit_ready = 1'b0; set_seg(7'h79);
      run_until_valid(10, e);
      check("s6_pending", e, 5);
      reset = 1'b1; tick();
      check("s6_valid", digit_valid, 0);
      check("s6_digit", {O0, O1, O2, O3}, 0);
      check("s6_ecnt", err_count, 0);
      reset = 1'b0; set_seg('0);
      vc0 = dut_vcyc;
      ticks(12);
      check("s6_no_stale", dut_vcyc - vc0, 0);

      // Saturation of the error counter
      digit_ready = 1'b1;
      ep0 = dut_errp;
      for (int i = 0; i < 256; i++) begin
         set_seg(7'h7F); ticks(6);
         set_seg('0);    ticks(6);
      end
      check("sat_count", err_count, 255);
      check("sat_pulses", dut_errp - ep0, 256);

      // Random glyph streams with random back-pressure
      for (int s = 0; s < 400; s++) begin
         int kind, len;
         kind = $urandom_range(0, 3);
         len  = $urandom_range(1, 8);
         case (kind)
            0: set_seg(pats[$urandom_range(0, 9)]);
            1: set_seg('0);
            2: set_seg(7'($urandom));
            default: ;
         endcase
         for (int c = 0; c < len; c++) begin
            digit_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
